// File: rtl/mem_model_ctrl_if.sv
// Request/response types and the cache <-> main-memory interface.
// The master side is the cache; the slave side is mem_model_ctrl.
package mem_model_pkg;
  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;
endpackage

interface mem_model_ctrl_if;
  import mem_model_pkg::*;

  mem_req_type  mem_req;
  mem_data_type mem_data;
  logic         busy;

  modport master (output mem_req, input mem_data, input busy);
  modport slave  (input mem_req, output mem_data, output busy);
endinterface

// File: rtl/mem_model_ctrl.sv
// Main-memory model: 128-bit line fill / write-back with fixed LATENCY and a one-cycle ready.
// Define MEM_MODEL_STATS_EN to add the rd_count / wr_count / ignored_count statistics outputs.
module mem_model_ctrl
  import mem_model_pkg::*;
#(
  parameter  int LATENCY   = 4,
  parameter  int MEM_LINES = 4096,
  localparam int IDXW      = $clog2(MEM_LINES)
) (
  input  logic               clk,
  input  logic               rst,
  mem_model_ctrl_if.slave    bus
`ifdef MEM_MODEL_STATS_EN
  ,
  output logic [31:0]        rd_count,
  output logic [31:0]        wr_count,
  output logic [15:0]        ignored_count
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [7:0] CNT_LOAD = 8'((LATENCY > 1) ? LATENCY - 2 : 0);

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            accept;
  logic [IDXW-1:0] idx;
  logic [127:0]    line_now;
  logic [127:0]    rdata_q;
  logic [127:0]    data_q;
  logic            ready_q;

  logic [127:0] mem [MEM_LINES];

  assign idx = bus.mem_req.addr[4 +: IDXW];
  // The response payload of a write-back is the written line itself.
  assign line_now = bus.mem_req.rw ? bus.mem_req.data : mem[idx];

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (bus.mem_req.valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      ready_q <= 1'b0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == RESP);
      if (accept) rdata_q <= line_now;
      // With LATENCY=1 the response is formed at the accepting edge itself.
      if (state_d == RESP) data_q <= accept ? line_now : rdata_q;
    end
  end

  // NOTE: the line array has no reset; contents survive rst, only the write strobe is gated.
  always_ff @(posedge clk) begin
    if (!rst && accept && bus.mem_req.rw) mem[idx] <= bus.mem_req.data;
  end

  assign bus.mem_data = '{data: data_q, ready: ready_q};
  assign bus.busy     = (state_q == BUSY);

`ifdef MEM_MODEL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count      <= '0;
      wr_count      <= '0;
      ignored_count <= '0;
    end else begin
      if (accept &&  bus.mem_req.rw) wr_count <= wr_count + 32'd1;
      if (accept && !bus.mem_req.rw) rd_count <= rd_count + 32'd1;
      if (state_q == BUSY && bus.mem_req.valid && ignored_count != 16'hFFFF)
        ignored_count <= ignored_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_model_ctrl.sv
// Directed bench for mem_model_ctrl: a LATENCY=4 instance and a LATENCY=1 instance.
module tb_mem_model_ctrl;
  import mem_model_pkg::*;

  localparam logic [127:0] DEAD = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] A5   = 128'hA5A5_A5A5_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] CAFE = 128'h00C0_FFEE_00C0_FFEE_0000_0000_0000_0001;
  localparam logic [127:0] L80  = 128'h1234;
  localparam logic [127:0] L40  = 128'h4040_0000_0000_0000_0000_0000_0000_0040;
  localparam logic [127:0] W1   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] W2   = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_model_ctrl_if bus4 ();
  mem_model_ctrl_if bus1 ();

`ifdef MEM_MODEL_STATS_EN
  logic [31:0] rd4, wr4, rd1, wr1;
  logic [15:0] ign4, ign1;
`endif

  mem_model_ctrl #(.LATENCY(4), .MEM_LINES(4096)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
`ifdef MEM_MODEL_STATS_EN
    , .rd_count (rd4), .wr_count (wr4), .ignored_count (ign4)
`endif
  );

  mem_model_ctrl #(.LATENCY(1), .MEM_LINES(4096)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
`ifdef MEM_MODEL_STATS_EN
    , .rd_count (rd1), .wr_count (wr1), .ignored_count (ign1)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]  addr;
    logic         rw;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  // One request on the LATENCY=4 instance; checks ready timing, payload and single-cycle pulse.
  task automatic req4(input string name, input logic [31:0] a, input logic rw,
                      input logic [127:0] d, input logic [127:0] exp);
    int  k;
    bit  seen;
    @(negedge clk);
    bus4.mem_req = '{addr: a, data: d, rw: rw, valid: 1'b1};
    @(negedge clk);
    bus4.mem_req.valid = 1'b0;
    check({name, "_busy"}, 128'(bus4.busy), 128'(1));
    check({name, "_early"}, 128'(bus4.mem_data.ready), 128'(0));
    k = 1;
    seen = 1'b0;
    while (!seen && k < 12) begin
      @(negedge clk);
      k++;
      if (bus4.mem_data.ready) seen = 1'b1;
    end
    check({name, "_lat"}, 128'(seen ? k : 0), 128'(4));
    check({name, "_data"}, bus4.mem_data.data, exp);
    @(negedge clk);
    check({name, "_once"}, 128'(bus4.mem_data.ready), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   k, extra;
    bit   seen;
`ifdef MEM_MODEL_STATS_EN
    logic [15:0] ign_base;
`endif

    vecs[0] = '{addr: 32'h0000_0120, rw: 1'b1, data: DEAD, exp: DEAD};
    vecs[1] = '{addr: 32'h0000_0120, rw: 1'b0, data: '0,   exp: DEAD};
    vecs[2] = '{addr: 32'h0001_0010, rw: 1'b1, data: A5,   exp: A5};
    vecs[3] = '{addr: 32'h0000_0010, rw: 1'b0, data: '0,   exp: A5};
    vecs[4] = '{addr: 32'h0000_0080, rw: 1'b1, data: L80,  exp: L80};
    vecs[5] = '{addr: 32'h0000_012C, rw: 1'b1, data: CAFE, exp: CAFE};
    vecs[6] = '{addr: 32'hF000_012F, rw: 1'b0, data: '0,   exp: CAFE};
    vecs[7] = '{addr: 32'h0000_0080, rw: 1'b0, data: '0,   exp: L80};

    rst = 1'b1;
    bus4.mem_req = '0;
    bus1.mem_req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ctl", 128'({bus4.mem_data.ready, bus4.busy, bus1.mem_data.ready, bus1.busy}), 128'(0));
      check("idle_data", bus4.mem_data.data | bus1.mem_data.data, 128'(0));
    end

    for (int i = 0; i < 8; i++)
      req4($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rw, vecs[i].data, vecs[i].exp);

    // Back-to-back write-back (0x40) then fill (0x80) presented in the RESP cycle
    @(negedge clk);
    bus4.mem_req = '{addr: 32'h40, data: L40, rw: 1'b1, valid: 1'b1};
    @(negedge clk);
    bus4.mem_req.valid = 1'b0;
    k = 1;
    seen = 1'b0;
    while (!seen && k < 12) begin
      @(negedge clk);
      k++;
      if (bus4.mem_data.ready) seen = 1'b1;
    end
    check("b2b_wr_lat", 128'(seen ? k : 0), 128'(4));
    check("b2b_wr_data", bus4.mem_data.data, L40);
    bus4.mem_req = '{addr: 32'h80, data: '0, rw: 1'b0, valid: 1'b1};
    @(negedge clk);
    bus4.mem_req.valid = 1'b0;
    check("b2b_rd_ready0", 128'(bus4.mem_data.ready), 128'(0));
    k = 1;
    seen = 1'b0;
    while (!seen && k < 12) begin
      check("b2b_busy", 128'(bus4.busy), 128'(1));
      @(negedge clk);
      k++;
      if (bus4.mem_data.ready) seen = 1'b1;
    end
    check("b2b_rd_lat", 128'(seen ? k : 0), 128'(4));
    check("b2b_rd_data", bus4.mem_data.data, L80);
    @(negedge clk);
    check("b2b_once", 128'(bus4.mem_data.ready), 128'(0));

    // Valid held through BUSY: one response only
`ifdef MEM_MODEL_STATS_EN
    ign_base = ign4;
`endif
    @(negedge clk);
    bus4.mem_req = '{addr: 32'h80, data: '0, rw: 1'b0, valid: 1'b1};
    k = 0;
    seen = 1'b0;
    while (!seen && k < 12) begin
      @(negedge clk);
      k++;
      if (bus4.mem_data.ready) seen = 1'b1;
    end
    bus4.mem_req.valid = 1'b0;
    check("hold_lat", 128'(seen ? k : 0), 128'(4));
    check("hold_data", bus4.mem_data.data, L80);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus4.mem_data.ready) extra++;
    end
    check("hold_one_ready", 128'(extra), 128'(0));
`ifdef MEM_MODEL_STATS_EN
    check("hold_ignored", 128'(ign4 - ign_base), 128'(3));
`endif

    // Reset two edges after acceptance discards the request
    @(negedge clk);
    bus4.mem_req = '{addr: 32'h10, data: '0, rw: 1'b0, valid: 1'b1};
    @(negedge clk);
    bus4.mem_req.valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus4.mem_data.ready || bus4.busy) extra++;
    end
    check("rst_no_ready", 128'(extra), 128'(0));
    check("rst_data", bus4.mem_data.data, 128'(0));
    req4("post_rst", 32'h10, 1'b0, '0, A5);

    // LATENCY=1 instance: back-to-back requests, ready on consecutive cycles
    @(negedge clk);
    bus1.mem_req = '{addr: 32'h30, data: W1, rw: 1'b1, valid: 1'b1};
    @(negedge clk);
    check("l1_w1_ready", 128'({bus1.mem_data.ready, bus1.busy}), 128'(2'b10));
    check("l1_w1_data", bus1.mem_data.data, W1);
    bus1.mem_req = '{addr: 32'h50, data: W2, rw: 1'b1, valid: 1'b1};
    @(negedge clk);
    check("l1_w2_ready", 128'({bus1.mem_data.ready, bus1.busy}), 128'(2'b10));
    check("l1_w2_data", bus1.mem_data.data, W2);
    bus1.mem_req = '{addr: 32'h30, data: '0, rw: 1'b0, valid: 1'b1};
    @(negedge clk);
    check("l1_r1_ready", 128'(bus1.mem_data.ready), 128'(1));
    check("l1_r1_data", bus1.mem_data.data, W1);
    bus1.mem_req = '{addr: 32'h50, data: '0, rw: 1'b0, valid: 1'b1};
    @(negedge clk);
    check("l1_r2_ready", 128'(bus1.mem_data.ready), 128'(1));
    check("l1_r2_data", bus1.mem_data.data, W2);
    bus1.mem_req.valid = 1'b0;
    @(negedge clk);
    check("l1_idle", 128'({bus1.mem_data.ready, bus1.busy}), 128'(0));
    check("l1_hold_data", bus1.mem_data.data, W2);
`ifdef MEM_MODEL_STATS_EN
    check("l1_rd_count", 128'(rd1), 128'(2));
    check("l1_wr_count", 128'(wr1), 128'(2));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
